// File: rtl/sd_iterativo.sv
// Iterative generalised-Fibonacci bus datapath: {A,B} <- {B, A op B} repeated iter times, final B to C.
// Optional macro SAT_EN: ALU results saturate (carry -> all-ones, borrow -> zero) instead of wrapping.
module sd_iterativo #(
   parameter int unsigned N  = 8,
   parameter int unsigned IW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          xs,
   input  logic          op,
   input  logic [IW-1:0] iter,
   input  logic [N-1:0]  a_in,
   input  logic [N-1:0]  b_in,
   output logic          busy,
   output logic          fin,
   output logic [N-1:0]  result,
   output logic          ovf
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      TA   = 3'd1,
      ALU  = 3'd2,
      AB   = 3'd3,
      BAC  = 3'd4,
      WB   = 3'd5,
      FIN  = 3'd6
   } state_t;

   state_t        state;
   state_t        state_next;

   logic [N-1:0]  reg_a;
   logic [N-1:0]  reg_b;
   logic [N-1:0]  reg_t;
   logic [N-1:0]  reg_ac;
   logic [IW-1:0] cnt;
   logic          op_q;

   logic [N:0]    sum;
   logic [N-1:0]  diff;
   logic          borrow;
   logic [N-1:0]  alu_res;
   logic          alu_flag;

   // ALU between T and B; flag is carry-out for add, borrow for subtract
   always_comb begin
      sum      = {1'b0, reg_t} + {1'b0, reg_b};
      diff     = reg_t - reg_b;
      borrow   = (reg_t < reg_b);
      alu_res  = '0;
      alu_flag = 1'b0;
      if (!op_q) begin
         alu_flag = sum[N];
`ifdef SAT_EN
         alu_res  = sum[N] ? '1 : sum[N-1:0];
`else
         alu_res  = sum[N-1:0];
`endif
      end else begin
         alu_flag = borrow;
`ifdef SAT_EN
         alu_res  = borrow ? '0 : diff;
`else
         alu_res  = diff;
`endif
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; the last BAC step (cnt==1) exits to write-back
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (xs) begin
               state_next = (iter != '0) ? TA : WB;
            end
         end
         TA:      state_next = ALU;
         ALU:     state_next = AB;
         AB:      state_next = BAC;
         BAC:     state_next = (cnt != IW'(1)) ? TA : WB;
         WB:      state_next = FIN;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers: one bus transfer per micro-step
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_a  <= '0;
         reg_b  <= '0;
         reg_t  <= '0;
         reg_ac <= '0;
         cnt    <= '0;
         op_q   <= 1'b0;
         result <= '0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (xs) begin
                  reg_a <= a_in;
                  reg_b <= b_in;
                  cnt   <= iter;
                  op_q  <= op;
                  ovf   <= 1'b0;
               end
            end
            TA:  reg_t <= reg_a;
            ALU: begin
               reg_ac <= alu_res;
               ovf    <= ovf | alu_flag;
            end
            AB:  reg_a <= reg_b;
            BAC: begin
               reg_b <= reg_ac;
               cnt   <= cnt - IW'(1);
            end
            WB:  result <= reg_b;
            default: ;
         endcase
      end
   end

   // Status outputs registered from the next state so they align with it
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
         fin  <= 1'b0;
      end else begin
         busy <= (state_next != IDLE);
         fin  <= (state_next == FIN);
      end
   end

endmodule

// File: doc/sd_iterativo.md
# sd_iterativo

Parametrised successor to the fixed-sequence bus datapath. Registers A, B, C, T and AC share a one-transfer-per-cycle micro-step discipline, and an add/subtract ALU sits between T and AC. Each iteration performs a programmable generalised Fibonacci step, `{A,B} <- {B, A op B}`, repeated a run-time number of times. The final B is written to C and `fin` pulses. The block sits under the digital-system top and is started by `xs`, as before.

## Interface
Parameters:
- N, 8, data width of all registers, buses and ALU.
- IW, 4, width of the iteration-count input.

Ports:
- clk in 1: single clock; all state updates on rising edge.
- reset in 1: synchronous, active-high; sampled on the `clk` rising edge.
- xs in 1: start request, sampled only in IDLE.
- op in 1: 0 = add (A+B), 1 = subtract (A−B); latched at start.
- iter in IW: iteration count; latched at start.
- a_in in N: initial A, loaded at start.
- b_in in N: initial B, loaded at start.
- busy out 1: high in every state except IDLE.
- fin out 1: one-cycle completion pulse.
- result out N: C register; holds its value until the next run writes it.
- ovf out 1: sticky overflow/borrow flag for the current run.

## Operation
- States: IDLE, TA, ALU, AB, BAC, WB, FIN.
- IDLE with xs=1 performs all of the following at that edge:
  - A<=a_in, B<=b_in, cnt<=iter, op latched, ovf<=0.
  - Next state is TA if iter≠0, else WB.
- IDLE with xs=0: stay in IDLE.
- Per-iteration micro-steps, one cycle each:
  - TA: T<=A.
  - ALU: AC<=T op B; ovf |= carry-out (add) or borrow (sub).
  - AB: A<=B.
  - BAC: B<=AC; cnt<=cnt−1. Next state is TA if cnt≠1, else WB.
- WB: C<=B. Next state FIN.
- FIN: fin=1. Next state IDLE.
- Arithmetic is unsigned N-bit.
  - Add: carry = bit N of the (N+1)-bit sum.
  - Sub: borrow = T<B.
- xs is ignored while busy; a start is never queued.
- Outputs are registered or decoded directly from state; no combinational path from inputs to outputs.

## Timing
- Reset: state=IDLE; A, B, C, T, AC and cnt = 0; busy=0, fin=0, ovf=0, result=0.
- Reset mid-run: IDLE on the next edge; run aborted, fin is not asserted, C is cleared.
- Reset has priority over xs in the same cycle.
- Latency, counting the xs-sampling edge as edge 0:
  - fin is high in the cycle after edge 4·iter+1.
  - busy is high from edge 0 until edge 4·iter+2.
  - iter=0: fin follows edge 1.
- result changes only at the WB edge (or on reset) and is valid no later than fin.
- ovf is valid from the ALU edge that sets it and holds until the next start or reset.
- Back-to-back runs: xs high in the cycle after FIN starts a new run; fin never goes high in two consecutive cycles.
- iter = 2^IW − 1 must complete correctly, with no counter wrap.

## Configuration
- SAT_EN defined: ALU results saturate.
  - Add carry gives all-ones (2^N−1).
  - Sub borrow gives 0.
  - ovf is still set.
- SAT_EN undefined: results wrap modulo 2^N; ovf still flags the event.

## Test plan
- Fibonacci: N=8, a_in=0, b_in=1, op=0, iter=10, xs pulse → busy for 42 cycles, fin one cycle after edge 41, result=89, ovf=0.
- Add overflow: N=8, a_in=0, b_in=1, op=0, iter=13 → ovf=1; result=121 without SAT_EN, 255 with SAT_EN.
- Zero iterations: a_in=5, b_in=7, iter=0 → fin after edge 1, result=7, ovf=0, A/B untouched beyond the load.
- Subtract/borrow: a_in=10, b_in=3, op=1, iter=2 → first AC=7, second AC underflows; result=252 without SAT_EN, 0 with SAT_EN; ovf=1.
- Abort and ignore:
  - Reset asserted during the ALU step of iteration 2 (iter=5) → busy=0 after the next edge, fin never pulses, result=0.
  - A separate xs pulse mid-run → ignored, fin timing unchanged.
- Back-to-back: second xs in the cycle after fin, with new a_in=2, b_in=3, iter=1 → second fin after edge 5 of the new run, result=5, ovf cleared at the restart.
